// File: rtl/cdc_fifo_wr_arbiter.sv
// cdc_fifo_wr_arbiter
// Shares the write port of a single asynchronous FIFO among NUM_REQ requesters
// that live in the FIFO write-clock domain. Grants rotate round-robin. A granted
// requester keeps the port until it marks a word as last or MAX_BURST beats have
// been written. The FIFO full flag gates the handshake in the same cycle.
module cdc_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   beat_total
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]     beat_total_q, beat_total_d;
  logic            busy_q, busy_d;

  logic            pick_found_s;
  logic [IDW-1:0]  pick_id_s;
  logic [IDW-1:0]  scan_idx_s;
  logic            gnt_valid_s;
  logic            gnt_last_s;
  logic [DATA_WIDTH-1:0] gnt_data_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic            xfer_s;
  logic            burst_end_s;

  // Round-robin pick: first valid requester after the last one granted.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    scan_idx_s   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx_s = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_found_s && req_valid[scan_idx_s]) begin
        pick_found_s = 1'b1;
        pick_id_s    = scan_idx_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Select the granted requester's word and handshake; full or reset block the beat.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_last_s  = 1'b0;
    gnt_data_s  = '0;
    req_ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        gnt_valid_s    = req_valid[i];
        gnt_last_s     = req_last[i];
        gnt_data_s     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready_s[i] = (state_q == ST_GRANT) && !fifo_wr_full && !rst;
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
    xfer_s      = (state_q == ST_GRANT) && gnt_valid_s && !fifo_wr_full && !rst;
    burst_end_s = gnt_last_s || (beat_cnt_q == BCW'(MAX_BURST - 1));
  end

  // Next-state logic: arbitrate in IDLE, count beats and release the lock in GRANT.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    beat_total_d = beat_total_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d      = ST_GRANT;
          grant_id_d   = pick_id_s;
          last_grant_d = pick_id_s;
          beat_cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (xfer_s) begin
          beat_total_d = beat_total_q + 16'd1;
          if (burst_end_s) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_GRANT);
  end

  // State registers with synchronous reset; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      beat_total_q <= 16'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_total_q <= beat_total_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready    = req_ready_s;
  assign fifo_wr_en   = xfer_s;
  assign fifo_wr_data = gnt_data_s;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign beat_total   = beat_total_q;

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Scoreboard bench for cdc_fifo_wr_arbiter. A transaction-level reference model
// predicts each cycle's outputs from the driven inputs; a monitor compares them.
module tb_cdc_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_last;
  logic [NR-1:0]  req_ready;
  logic           fifo_wr_en;
  logic [DW-1:0]  fifo_wr_data;
  logic           fifo_wr_full;
  logic [1:0]     grant_id;
  logic           busy;
  logic [15:0]    beat_total;

  cdc_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .grant_id(grant_id), .busy(busy), .beat_total(beat_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        wr;
    logic [7:0]  data;
    logic [1:0]  gid;
    logic        busy;
    logic [3:0]  ready;
    logic [15:0] total;
  } rec_t;

  rec_t        sb[$];
  rec_t        mon_r;
  logic [8:0]  src[NR][$];   // {last, data} words waiting at each requester
  logic [1:0]  wr_log[$];
  logic [NR-1:0] en;
  logic [NR-1:0] fire;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        first_cyc = 1'b1;

  // reference model: who owns the port, rotation pointer, beats in this burst
  logic        m_busy = 1'b0;
  int          m_owner = 0;
  int          m_ptr = NR - 1;
  logic [1:0]  m_gid = 2'd0;
  int          m_cnt = 0;
  logic [15:0] m_total = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (src[i].size() > 0);
      req_data[i*DW +: DW] = (src[i].size() > 0) ? src[i][0][7:0] : 8'h00;
      req_last[i] = (src[i].size() > 0) ? src[i][0][8] : 1'b0;
    end
  endtask

  task automatic model_step();
    rec_t e;
    e.chk   = !first_cyc;
    first_cyc = 1'b0;
    e.busy  = m_busy;
    e.gid   = m_gid;
    e.total = m_total;
    e.ready = 4'b0000;
    e.wr    = 1'b0;
    e.data  = 8'h00;
    if (rst) begin
      m_busy = 1'b0; m_ptr = NR - 1; m_gid = 2'd0; m_cnt = 0; m_total = 16'd0;
    end else if (!m_busy) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (!m_busy && req_valid[idx]) begin
          m_busy = 1'b1; m_owner = idx; m_ptr = idx; m_gid = 2'(idx); m_cnt = 0;
        end
      end
    end else begin
      e.ready[m_owner] = !fifo_wr_full;
      if (req_valid[m_owner] && !fifo_wr_full) begin
        e.wr = 1'b1;
        e.data = src[m_owner][0][7:0];
        m_total = m_total + 16'd1;
        m_cnt++;
        if (src[m_owner][0][8] || m_cnt == MB) m_busy = 1'b0;
      end
    end
    sb.push_back(e);
  endtask

  // one clock: drive inputs, predict, then retire words the DUT accepted
  task automatic cycle(input logic r, input logic f);
    rst = r;
    fifo_wr_full = f;
    drive();
    model_step();
    @(negedge clk);
    fire = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (fire[i]) void'(src[i].pop_front());
    end
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < NR; i++) n += src[i].size();
    return n;
  endfunction

  // monitor: compare every presented cycle against the model's prediction
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) wr_log.push_back(grant_id);
    if (sb.size() > 0) begin
      mon_r = sb.pop_front();
      if (mon_r.chk) begin
        vectors++;
        if (fifo_wr_en !== mon_r.wr || busy !== mon_r.busy || grant_id !== mon_r.gid ||
            req_ready !== mon_r.ready || beat_total !== mon_r.total ||
            (mon_r.wr && fifo_wr_data !== mon_r.data)) begin
          miscompares++;
          $display("FAIL cycle@%0t: wr_en %b/%b data %h/%h gid %0d/%0d busy %b/%b ready %b/%b total %0d/%0d (got/exp)",
                   $time, fifo_wr_en, mon_r.wr, fifo_wr_data, mon_r.data, grant_id, mon_r.gid,
                   busy, mon_r.busy, req_ready, mon_r.ready, beat_total, mon_r.total);
        end
      end
    end
  end

  initial begin
    int n2;
    int budget;
    rst = 1'b1; fifo_wr_full = 1'b0; en = '0;
    req_valid = '0; req_data = '0; req_last = '0; fire = '0;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);

    // reset then a single one-word burst from requester 0
    wr_log.delete();
    src[0].push_back({1'b1, 8'hA5});
    en = 4'b1111;
    repeat (4) cycle(1'b0, 1'b0);
    chk("first_total", 32'(beat_total), 32'd1);
    chk("first_writes", wr_log.size(), 32'd1);
    chk("first_gid", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hFFFF, 32'd0);

    // round-robin fairness: everyone valid, one-word bursts
    cycle(1'b1, 1'b0);
    wr_log.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) src[i].push_back({1'b1, 8'($urandom)});
    repeat (20) cycle(1'b0, 1'b0);
    chk("rr_writes", wr_log.size(), 32'd8);
    for (int k = 0; k < 8; k++)
      chk("rr_order", (wr_log.size() > k) ? 32'(wr_log[k]) : 32'hFFFF, 32'(k % NR));
    chk("rr_total", 32'(beat_total), 32'd8);

    // burst cap: requester 2 streams ten words without last
    cycle(1'b1, 1'b0);
    wr_log.delete();
    for (int k = 0; k < 10; k++) src[2].push_back({1'b0, 8'($urandom)});
    repeat (30) cycle(1'b0, 1'b0);
    n2 = 0;
    foreach (wr_log[k]) if (wr_log[k] == 2'd2) n2++;
    chk("cap_writes_req2", n2, 32'd10);
    chk("cap_total", 32'(beat_total), 32'd10);

    // back-pressure: full for five cycles after two beats
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) src[1].push_back({(k == 3) ? 1'b1 : 1'b0, 8'($urandom)});
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0);
    chk("full_total", 32'(beat_total), 32'd4);
    chk("full_drained", src[1].size(), 32'd0);

    // reset mid-burst, then requester 0 wins the next arbitration
    en = 4'b0001;
    for (int k = 0; k < 4; k++) src[0].push_back({(k == 3) ? 1'b1 : 1'b0, 8'($urandom)});
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_total", 32'(beat_total), 32'd0);
    wr_log.delete();
    src[3].push_back({1'b0, 8'h3C});
    src[3].push_back({1'b1, 8'h3D});
    en = 4'b1111;
    repeat (15) cycle(1'b0, 1'b0);
    chk("rstmid_next_gid", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hFFFF, 32'd0);

    // randomized traffic with dropped valids, full stalls and rare resets
    cycle(1'b1, 1'b0);
    for (int i = 0; i < NR; i++) begin
      src[i].delete();
      for (int k = 0; k < 20; k++)
        src[i].push_back({(k == 19) || ($urandom_range(0, 3) == 0), 8'($urandom)});
    end
    repeat (1500) begin
      for (int i = 0; i < NR; i++) en[i] = ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 4) == 0));
      if (pending() == 0) begin
        for (int i = 0; i < NR; i++)
          for (int k = 0; k < 20; k++)
            src[i].push_back({(k == 19) || ($urandom_range(0, 3) == 0), 8'($urandom)});
      end
    end
    en = 4'b1111;
    budget = 0;
    while (pending() > 0 && budget < 600) begin
      cycle(1'b0, 1'b0);
      budget++;
    end
    chk("drain_left", pending(), 32'd0);
    repeat (2) cycle(1'b0, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
